piano_voice_scheduler: RTL

Monophonic voice scheduler for the piano. It debounces 8 key inputs (C4..C5) and picks one active note by last-pressed priority. It drives a single shared programmable square-wave tone generator with that note's half-period. The speaker output goes straight to the board pin; one generator serves all keys instead of one fixed-divider generator per note.

---
 rtl/piano_voice_scheduler_pkg.sv | 35 +++
 rtl/piano_voice_scheduler_tone_gen.sv | 40 ++++
 rtl/piano_voice_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/piano_voice_scheduler_pkg.sv
// piano_pkg: shared constants for the piano voice scheduler.
//   NUM_KEYS    - number of key inputs (C4..C5)
//   NOTE_W      - width of a note index
//   CNT_W       - tone counter width (holds largest half-period - 1)
//   HALF_PERIOD - square-wave half-period per note, in 50 MHz cycles
//   msb_index   - index of the highest set bit of a key vector
package piano_pkg;

  localparam int unsigned NUM_KEYS = 8;
  localparam int unsigned NOTE_W   = 3;
  localparam int unsigned CNT_W    = 17;

  // Index 0 = C4 ... index 7 = C5.
  localparam logic [CNT_W-1:0] HALF_PERIOD [NUM_KEYS] = '{
    17'd95556,  // C4
    17'd85131,  // D4
    17'd75843,  // E4
    17'd71586,  // F4
    17'd63776,  // G4
    17'd56818,  // A4
    17'd50619,  // B4
    17'd47778   // C5
  };

  // Highest-index set bit; returns 0 for an all-zero vector.
  function automatic logic [NOTE_W-1:0] msb_index(input logic [NUM_KEYS-1:0] v);
    logic [NOTE_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) idx = NOTE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/piano_voice_scheduler_tone_gen.sv
// piano_tone_gen: programmable square-wave generator.
//   clk         - system clock
//   rst         - synchronous active-high reset
//   en          - 1 while a note is sounding; 0 forces counter and speaker to 0
//   half_period - toggle interval in cycles (period = 2*half_period)
//   restart     - clear the counter without disturbing the speaker level
//   speaker     - square-wave output
module piano_tone_gen #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] half_period,
  input  logic             restart,
  output logic             speaker
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_speaker;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt     <= '0;
      r_speaker <= 1'b0;
    end else if (restart) begin
      // Restart has priority so a stale count from the previous half-period
      // never reaches the wrap comparison.
      r_cnt <= '0;
    end else if (r_cnt == half_period - CNT_W'(1)) begin
      r_cnt     <= '0;
      r_speaker <= ~r_speaker;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign speaker = r_speaker;

endmodule

// File: rtl/piano_voice_scheduler.sv
// piano_voice_scheduler: monophonic last-pressed-priority voice scheduler.
//   clk          - system clock (50 MHz)
//   rst          - synchronous active-high reset
//   keys         - raw asynchronous key levels, 1 = pressed, bit0 = C4 .. bit7 = C5
//   speaker      - square-wave audio output
//   active_valid - 1 while a note is sounding
//   active_note  - index of the sounding note, 0 when silent
//   note_change  - one-cycle pulse after active_valid/active_note change
// Pipeline: 2-flop sync -> per-key debounce -> registered edge events ->
// arbiter -> shared programmable tone generator.
module piano_voice_scheduler
  import piano_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                speaker,
  output logic                active_valid,
  output logic [NOTE_W-1:0]   active_note,
  output logic                note_change
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_deb;
  logic [NUM_KEYS-1:0] r_deb_d;
  logic [NUM_KEYS-1:0] r_press;
  logic [NUM_KEYS-1:0] r_rel;
  logic [DB_W-1:0]     r_db_cnt [NUM_KEYS];

  logic                r_valid;
  logic [NOTE_W-1:0]   r_note;
  logic                r_note_change;

  logic                w_valid_nxt;
  logic [NOTE_W-1:0]   w_note_nxt;
  logic [NUM_KEYS-1:0] w_held_others;
  logic [CNT_W-1:0]    w_half;
  logic                w_speaker;

  // Synchronizer, debounce and registered edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_press <= '0;
      r_rel   <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= keys;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_MAX) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
      r_deb_d <= r_deb;
      r_press <= r_deb & ~r_deb_d;
      r_rel   <= ~r_deb & r_deb_d;
    end
  end

  // Keys still held other than the currently active one.
  always_comb begin
    w_held_others         = r_deb;
    w_held_others[r_note] = 1'b0;
  end

  // Arbiter: any press wins (highest index); releasing the active note falls
  // back to the highest held key or goes silent; other releases are ignored.
  always_comb begin
    w_valid_nxt = r_valid;
    w_note_nxt  = r_note;
    if (|r_press) begin
      w_valid_nxt = 1'b1;
      w_note_nxt  = msb_index(r_press);
    end else if (r_valid && r_rel[r_note]) begin
      if (|w_held_others) begin
        w_note_nxt = msb_index(w_held_others);
      end else begin
        w_valid_nxt = 1'b0;
        w_note_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_note        <= '0;
      r_note_change <= 1'b0;
    end else begin
      r_valid       <= w_valid_nxt;
      r_note        <= w_note_nxt;
      r_note_change <= (w_valid_nxt != r_valid) || (w_note_nxt != r_note);
    end
  end

  assign w_half = CNT_W'(HALF_PERIOD[r_note]);

  piano_tone_gen #(
    .CNT_W(CNT_W)
  ) u_tone_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (r_valid),
    .half_period(w_half),
    .restart    (r_note_change),
    .speaker    (w_speaker)
  );

  assign speaker      = w_speaker;
  assign active_valid = r_valid;
  assign active_note  = r_note;
  assign note_change  = r_note_change;

endmodule
